// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: drives an external 1-bit ALU slice LSB first to perform WIDTH-bit operations with carry/zero/overflow flags
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, acc, nxt;
  logic [2:0]       op_q;
  logic             cy, arith, last;
  assign arith   = op_q == 3'd2 || op_q == 3'd3;
  assign last    = idx == IW'(WIDTH - 1);
  assign busy    = state == RUN;
  assign done    = state == DONE;
  assign alu_a   = busy & a_q[idx];
  assign alu_b   = busy & b_q[idx];
  assign alu_cin = busy & arith & cy;
  assign alu_op  = op_q;
  always_comb begin
    nxt      = acc;
    nxt[idx] = alu_result;
  end
  // On the last bit cy still holds the carry into the MSB, which is what overflow needs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cy       <= 1'b0;
      acc      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      a_q   <= a_in;
      b_q   <= b_in;
      op_q  <= op;
      cy    <= op == 3'd3;
      idx   <= '0;
      state <= RUN;
    end else if (busy) begin
      acc <= nxt;
      idx <= idx + IW'(1);
      if (arith) cy <= alu_cout;
      if (last) begin
        state    <= DONE;
        result   <= nxt;
        zero     <= ~|nxt;
        carry    <= arith & alu_cout;
        overflow <= arith & (cy ^ alu_cout);
      end
    end else if (done) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: table-driven and scoreboard checks of the bit-serial sequencer with a behavioural slice
module tb_bit_serial_alu_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op_i = '0;
  logic [7:0] a_i = '0, b_i = '0;
  logic busy, done, carry, zero, overflow, alu_a, alu_b, alu_cin, alu_result, alu_cout;
  logic [7:0] result;
  logic [2:0] alu_op;
  int passed = 0, total = 0;
  typedef struct { logic [2:0] op; logic [7:0] a, b, res; logic c, z, v; } vec_t;
  vec_t sb[$];
  vec_t tbl[8];
  always #5 clk = ~clk;
  bit_serial_alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a_in(a_i), .b_in(b_i),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .overflow(overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );
  // slice: 0 AND, 1 OR, 2 ADD, 3 SUB (a+~b+cin), 4 XOR, 5 NAND, 6 NOR, 7 XNOR
  always_comb begin
    alu_result = 1'b0;
    alu_cout   = 1'b0;
    case (alu_op)
      3'd0: alu_result = alu_a & alu_b;
      3'd1: alu_result = alu_a | alu_b;
      3'd2: begin alu_result = alu_a ^ alu_b ^ alu_cin; alu_cout = (alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b)); end
      3'd3: begin alu_result = alu_a ^ ~alu_b ^ alu_cin; alu_cout = (alu_a & ~alu_b) | (alu_cin & (alu_a ^ ~alu_b)); end
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~(alu_a & alu_b);
      3'd6: alu_result = ~(alu_a | alu_b);
      default: alu_result = ~(alu_a ^ alu_b);
    endcase
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t e;
    logic [8:0] s;
    e.op = op; e.a = a; e.b = b; e.c = 1'b0; e.v = 1'b0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; e.res = s[7:0]; e.c = s[8]; e.v = (a[7] == b[7]) && (s[7] != a[7]); end
      3'd3: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; e.res = s[7:0]; e.c = s[8]; e.v = (a[7] != b[7]) && (s[7] != a[7]); end
      3'd4: e.res = a ^ b;
      3'd5: e.res = ~(a & b);
      3'd6: e.res = ~(a | b);
      default: e.res = ~(a ^ b);
    endcase
    e.z = e.res == 8'h00;
    return e;
  endfunction
  // expected carry into each bit position of the serial chain
  function automatic logic [7:0] cin_chain(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] bb, s;
    if (op != 3'd2 && op != 3'd3) return 8'h00;
    bb = op == 3'd3 ? ~b : b;
    s = a + bb + {7'd0, op == 3'd3};
    return a ^ bb ^ s;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      chk("busy_with_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        vec_t e;
        e = sb.pop_front();
        chk("result", {24'd0, result}, {24'd0, e.res});
        chk("carry", {31'd0, carry}, {31'd0, e.c});
        chk("zero", {31'd0, zero}, {31'd0, e.z});
        chk("overflow", {31'd0, overflow}, {31'd0, e.v});
      end
    end
  end
  task automatic run(input vec_t e, input int glitch);
    logic [7:0] cc;
    int k;
    cc = cin_chain(e.op, e.a, e.b);
    sb.push_back(e);
    @(negedge clk);
    op_i = e.op; a_i = e.a; b_i = e.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      if (k == glitch) begin start = 1'b1; op_i = ~e.op; a_i = ~e.a; b_i = 8'h77; end
      else if (k == glitch + 1) start = 1'b0;
      if (k < 8) begin
        chk("busy", {31'd0, busy}, 32'd1);
        chk("alu_cin", {31'd0, alu_cin}, {31'd0, cc[k]});
        chk("alu_a", {31'd0, alu_a}, {31'd0, e.a[k]});
        chk("alu_b", {31'd0, alu_b}, {31'd0, e.b[k]});
      end
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, 32'd8);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("alu_cin_idle", {31'd0, alu_cin}, 32'd0);
    chk("alu_op_held", {29'd0, alu_op}, {29'd0, e.op});
  endtask
  initial begin
    tbl[0] = '{3'd2, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{3'd3, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{3'd1, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'd3, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{3'd4, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {29'd0, carry, zero, overflow}, 32'd0);
    chk("rst_alu", {26'd0, alu_a, alu_b, alu_cin, alu_op}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) run(tbl[i], -1);
    for (int i = 0; i < 8; i++) run(model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)), -1);
    run(model(3'd2, 8'h21, 8'h43), 3);
    chk("glitch_result", {24'd0, result}, 32'h64);
    @(negedge clk);
    op_i = 3'd3; a_i = 8'h9C; b_i = 8'h35; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {24'd0, result}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    run(model(3'd2, 8'h01, 8'h02), -1);
    chk("after_abort_result", {24'd0, result}, 32'h03);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
